// File: rtl/e_mdu.sv
// e_mdu: execute-stage multiply/divide unit holding the architectural HI/LO
// registers. MULT/MULTU/DIV/DIVU run for a fixed number of cycles behind a
// busy flag; MTHI/MTLO write HI/LO in a single cycle while idle.
module e_mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdOp,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [2:0] {
        OP_NONE  = 3'd0,
        OP_MULT  = 3'd1,
        OP_MULTU = 3'd2,
        OP_DIV   = 3'd3,
        OP_DIVU  = 3'd4,
        OP_MTHI  = 3'd5,
        OP_MTLO  = 3'd6,
        OP_RSVD  = 3'd7
    } md_op_e;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    md_op_e           op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [2*WIDTH-1:0] ext_a, ext_b, prod;
    logic               a_neg, b_neg, is_div, commit_ok;
    logic [WIDTH-1:0]   mag_a, mag_b, div_b, quo_u, rem_u, quo, rem;
    logic [WIDTH-1:0]   res_hi, res_lo;

    assign busy = (cnt_q != '0);
    assign hi   = hi_q;
    assign lo   = lo_q;

    // Pending HI/LO computed from the operands latched at acceptance.
    // Signed division works on magnitudes and restores signs afterwards, which
    // also yields most-negative / 0 for the most-negative / -1 overflow case.
    always_comb begin
        is_div = (op_q == OP_DIV) || (op_q == OP_DIVU);
        ext_a  = (op_q == OP_MULT) ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
        ext_b  = (op_q == OP_MULT) ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
        prod   = ext_a * ext_b;

        a_neg  = (op_q == OP_DIV) && a_q[WIDTH-1];
        b_neg  = (op_q == OP_DIV) && b_q[WIDTH-1];
        mag_a  = a_neg ? (~a_q + 1'b1) : a_q;
        mag_b  = b_neg ? (~b_q + 1'b1) : b_q;
        div_b  = (b_q == '0) ? WIDTH'(1) : mag_b;
        quo_u  = mag_a / div_b;
        rem_u  = mag_a % div_b;
        quo    = (a_neg ^ b_neg) ? (~quo_u + 1'b1) : quo_u;
        rem    = a_neg ? (~rem_u + 1'b1) : rem_u;

        res_hi    = is_div ? rem : prod[2*WIDTH-1:WIDTH];
        res_lo    = is_div ? quo : prod[WIDTH-1:0];
        commit_ok = !(is_div && (b_q == '0));
    end

    // Next-state: count down while busy and commit on the last count; while
    // idle accept a new request (long op, MTHI/MTLO, or no-op codes).
    always_comb begin
        cnt_d = cnt_q;
        op_d  = op_q;
        a_d   = a_q;
        b_d   = b_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
            if ((cnt_q == CNT_W'(1)) && commit_ok) begin
                hi_d = res_hi;
                lo_d = res_lo;
            end
        end else if (start) begin
            case (md_op_e'(mdOp))
                OP_MULT, OP_MULTU: begin
                    cnt_d = CNT_W'(MULT_CYCLES);
                    op_d  = md_op_e'(mdOp);
                    a_d   = srcA;
                    b_d   = srcB;
                end
                OP_DIV, OP_DIVU: begin
                    cnt_d = CNT_W'(DIV_CYCLES);
                    op_d  = md_op_e'(mdOp);
                    a_d   = srcA;
                    b_d   = srcB;
                end
                OP_MTHI: hi_d = srcA;
                OP_MTLO: lo_d = srcA;
                default: ;
            endcase
        end
    end

    // State registers; asynchronous reset discards any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            op_q  <= OP_NONE;
            a_q   <= '0;
            b_q   <= '0;
            hi_q  <= '0;
            lo_q  <= '0;
        end else begin
            cnt_q <= cnt_d;
            op_q  <= op_d;
            a_q   <= a_d;
            b_q   <= b_d;
            hi_q  <= hi_d;
            lo_q  <= lo_d;
        end
    end

endmodule

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Parametrised multiply/divide unit for the execute stage; companion to the single-cycle E-stage ALU.
- Executes MULT, MULTU, DIV, DIVU with a configurable multi-cycle latency, and MTHI/MTLO in a single cycle.
- Holds the architectural HI/LO registers and drives a busy flag that the hazard unit uses to stall MD instructions in D.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (≥ 8).
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥ 1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥ 1).
- CNT_W, 4, counter width; must satisfy 2^CNT_W > max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  request: operation in mdOp is valid this cycle.
- mdOp  in  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none).
- srcA  in  WIDTH  rs operand; also the data source for MTHI/MTLO.
- srcB  in  WIDTH  rt operand.
- busy  out  1  long operation in progress (registered).
- hi  out  WIDTH  architectural HI register.
- lo  out  WIDTH  architectural LO register.

Behaviour:
- Reset (async, any time, including mid-operation): busy=0, hi=0, lo=0, counter=0, pending results=0; any in-flight operation is discarded.
- Acceptance: start is sampled at a rising edge only when busy=0. start with busy=1 is ignored, with no state change.
- Long operations (mdOp 1–4), accepted at edge k:
  - operands latched at edge k; pending {HI,LO} computed from the latched operands;
  - counter loads N (MULT_CYCLES or DIV_CYCLES);
  - busy=1 after edge k; counter decrements each edge;
  - at edge k+N: hi/lo take the pending results, busy=0 after that edge;
  - busy is high for exactly N cycles, and hi/lo hold their old values throughout.
- MULT: signed WIDTH×WIDTH → 2·WIDTH product; hi = upper half, lo = lower half.
- MULTU: same as MULT, unsigned.
- DIV: signed, truncating toward zero; lo = quotient, hi = remainder (remainder takes the sign of the dividend).
- DIVU: unsigned; lo = quotient, hi = remainder.
- Divide by zero (srcB=0, DIV or DIVU): full DIV_CYCLES latency; hi/lo unchanged at completion.
- Signed overflow (DIV, srcA = most-negative, srcB = −1): lo = most-negative, hi = 0; no exception.
- MTHI/MTLO (mdOp 5/6), busy=0: hi (or lo) = srcA at that edge; busy stays 0; 1-cycle effect.
- MTHI/MTLO while busy=1: ignored.
- start with mdOp 0 or 7: no effect.
- Back-to-back operations: a new start is accepted in the first cycle with busy=0. It sees, and may overwrite, the just-committed HI/LO.
- Counter state: idle (counter=0, busy=0) → run (counter>0, busy=1) → idle.
- busy = (counter≠0), driven from registers only; there is no combinational path from start to busy.
- hi and lo are direct register outputs; there is no combinational path from inputs.
- For N=1, busy is high for 1 cycle and results commit on the next edge.

Test Plan:
- Reset, then MULT srcA=0xFFFFFFFE (−2), srcB=3 → busy high exactly 5 cycles; afterwards hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- MULTU srcA=0xFFFFFFFF, srcB=0xFFFFFFFF → after 5 busy cycles, hi=0xFFFFFFFE, lo=0x00000001.
- DIV srcA=−7 (0xFFFFFFF9), srcB=2 → busy 10 cycles; lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1).
- DIVU 7/0 after MTHI 0x1234 and MTLO 0x5678 → busy 10 cycles; hi=0x1234, lo=0x5678 unchanged.
- DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- Busy-window collisions:
  - DIVU 100/7 started, then MTHI 0xAAAA and MULT asserted during busy → both ignored; hi=2, lo=14.
  - MTLO 0xBEEF in the first idle cycle after completion → lo=0xBEEF.
- Reset asserted asynchronously mid-MULT (cycle 3 of 5) → busy, hi, lo are 0 immediately; after reset release, no late commit occurs.
